// File: rtl/maxpool_2x2_stream_pkg.sv
// Shared accelerator parameters, pixel/lane types and lane-wise helpers.
// Used by the conv, upsample and maxpool stages.
package maxpool_2x2_stream_pkg;

    localparam int To           = 16;
    localparam int ACT_BITS     = 8;
    localparam int MAX_W        = 416;
    localparam int W_SIZE       = 9;
    localparam int FRAME_SIZE_W = 16;
    localparam int PIX_W        = To * ACT_BITS;
    localparam int LB_DEPTH     = MAX_W / 2;
    localparam int LB_AW        = $clog2(LB_DEPTH);

    typedef logic [PIX_W-1:0]           pix_t;
    typedef logic signed [ACT_BITS-1:0] act_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Lane i of a packed pixel, as a signed activation.
    function automatic act_t lane(input pix_t p, input int i);
        return act_t'(p[i*ACT_BITS +: ACT_BITS]);
    endfunction

    // Lane-wise signed max, no width growth; ties return the common value.
    function automatic pix_t vmax(input pix_t a, input pix_t b);
        pix_t r;
        act_t x;
        act_t y;
        r = '0;
        for (int i = 0; i < To; i++) begin
            x = lane(a, i);
            y = lane(b, i);
            r[i*ACT_BITS +: ACT_BITS] = (x > y) ? x : y;
        end
        return r;
    endfunction

endpackage

// File: rtl/maxpool_linebuf.sv
// Half-width line buffer holding the even-row horizontal maxima.
// Ports: clk; write port i_wr_en/i_wr_addr/i_wr_data;
//        read port i_rd_en/i_rd_addr -> o_rd_data (1-cycle, held when idle).
module maxpool_linebuf
    import maxpool_2x2_stream_pkg::*;
(
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [LB_AW-1:0] i_wr_addr,
    input  logic [PIX_W-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [LB_AW-1:0] i_rd_addr,
    output logic [PIX_W-1:0] o_rd_data
);

    logic [PIX_W-1:0] r_mem [LB_DEPTH];
    logic [PIX_W-1:0] r_rd_data;

    // Contents are never reset: every entry is written on the even row
    // before the odd row reads it.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster pixel stream.
// Ports: clk, rst (sync, high); start + q_width/q_height begin a frame;
//        vld_i/din input pixels; busy, vld_o/dout/out_count, done outputs.
module maxpool_2x2_stream
    import maxpool_2x2_stream_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [W_SIZE-1:0]       q_width,
    input  logic [W_SIZE-1:0]       q_height,
    input  logic                    vld_i,
    input  logic [PIX_W-1:0]        din,
    output logic                    busy,
    output logic                    vld_o,
    output logic [PIX_W-1:0]        dout,
    output logic [FRAME_SIZE_W-1:0] out_count,
    output logic                    done
);

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [W_SIZE-1:0]       r_w;
    logic [W_SIZE-1:0]       r_h;
    logic [W_SIZE-1:0]       r_col;
    logic [W_SIZE-1:0]       r_row;
    logic [PIX_W-1:0]        r_hold;
    logic [PIX_W-1:0]        r_dout;
    logic                    r_vld_o;
    logic                    r_done;
    logic [FRAME_SIZE_W-1:0] r_out_count;

    logic                    w_acc;
    logic                    w_col_last;
    logic                    w_row_last;
    logic                    w_odd_c;
    logic                    w_odd_r;
    logic [LB_AW-1:0]        w_lb_addr;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic [PIX_W-1:0]        w_rd_data;
    logic [PIX_W-1:0]        w_hmax;
    logic [PIX_W-1:0]        w_pool;

    // The done cycle is still RUN; no further beat belongs to this frame.
    assign w_acc      = (r_state == ST_RUN) && vld_i && !r_done;
    assign w_col_last = (r_col == (r_w - W_SIZE'(1)));
    assign w_row_last = (r_row == (r_h - W_SIZE'(1)));
    assign w_odd_c    = r_col[0];
    assign w_odd_r    = r_row[0];
    assign w_lb_addr  = LB_AW'(r_col >> 1);

    // Even row stores the pair max; odd row prefetches it on the even column.
    assign w_wr_en = w_acc &  w_odd_c & ~w_odd_r;
    assign w_rd_en = w_acc & ~w_odd_c &  w_odd_r;

    assign w_hmax = vmax(r_hold, din);
    assign w_pool = vmax(w_hmax, w_rd_data);

    maxpool_linebuf u_linebuf (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_lb_addr),
        .i_wr_data (w_hmax),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_lb_addr),
        .o_rd_data (w_rd_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_RUN;
            ST_RUN:  if (r_done) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        busy      = (r_state == ST_RUN);
        vld_o     = r_vld_o;
        dout      = r_dout;
        out_count = r_out_count;
        done      = r_done;
    end

    // Counters, hold register and pooled output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w         <= '0;
            r_h         <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_hold      <= '0;
            r_dout      <= '0;
            r_vld_o     <= 1'b0;
            r_done      <= 1'b0;
            r_out_count <= '0;
        end else begin
            r_vld_o <= 1'b0;
            r_done  <= 1'b0;
            if ((r_state == ST_IDLE) && start) begin
                r_w         <= q_width;
                r_h         <= q_height;
                r_col       <= '0;
                r_row       <= '0;
                r_hold      <= '0;
                r_out_count <= '0;
            end else begin
                // Index advances after the pixel it labels has been shown.
                if (r_vld_o) begin
                    r_out_count <= r_out_count + FRAME_SIZE_W'(1);
                end
                if (w_acc) begin
                    if (w_col_last) begin
                        r_col <= '0;
                        r_row <= w_row_last ? '0 : r_row + W_SIZE'(1);
                    end else begin
                        r_col <= r_col + W_SIZE'(1);
                    end
                    if (!w_odd_c) begin
                        r_hold <= din;
                    end else if (w_odd_r) begin
                        r_dout  <= w_pool;
                        r_vld_o <= 1'b1;
                        r_done  <= w_row_last && w_col_last;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Directed bench for maxpool_2x2_stream.
// Drives frames, captures vld_o beats and checks data, index, done, latency.
module tb_maxpool_2x2_stream;
    import maxpool_2x2_stream_pkg::*;

    localparam int DW = To * ACT_BITS;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [W_SIZE-1:0]       q_width;
    logic [W_SIZE-1:0]       q_height;
    logic                    vld_i;
    logic [DW-1:0]           din;
    logic                    busy;
    logic                    vld_o;
    logic [DW-1:0]           dout;
    logic [FRAME_SIZE_W-1:0] out_count;
    logic                    done;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int stray_done = 0;

    logic [DW-1:0] q_dout[$];
    int            q_idx[$];
    bit            q_done[$];
    int            q_cyc[$];
    int            exp_cyc[$];

    maxpool_2x2_stream dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .q_width   (q_width),
        .q_height  (q_height),
        .vld_i     (vld_i),
        .din       (din),
        .busy      (busy),
        .vld_o     (vld_o),
        .dout      (dout),
        .out_count (out_count),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (vld_o) begin
            q_dout.push_back(dout);
            q_idx.push_back(int'(out_count));
            q_done.push_back(done);
            q_cyc.push_back(cyc);
        end
        if (done && !vld_o) stray_done++;
    end

    function automatic logic [7:0] pv(int kind, int p, int l);
        int v;
        if (kind == 0) v = p;
        else if (kind == 1) begin
            if (l % 2 == 0) v = -128 + ((p * 3 + l) % 16);
            else            v = ((p * 5 + l) % 16) - 8;
        end else v = p + l;
        return 8'(v);
    endfunction

    function automatic logic [DW-1:0] pix(int kind, int p);
        logic [DW-1:0] r;
        r = '0;
        for (int l = 0; l < To; l++) r[l*8 +: 8] = pv(kind, p, l);
        return r;
    endfunction

    // Frame-level reference: signed max of the four pixels of window k.
    function automatic logic [DW-1:0] model(int kind, int w, int k);
        logic [DW-1:0] r;
        int pr;
        int pc;
        int base;
        int m;
        int v;
        int offs[4];
        pr = k / (w / 2);
        pc = k % (w / 2);
        base = 2 * pr * w + 2 * pc;
        offs = '{0, 1, w, w + 1};
        r = '0;
        for (int l = 0; l < To; l++) begin
            m = -1000;
            for (int j = 0; j < 4; j++) begin
                v = int'($signed(pv(kind, base + offs[j], l)));
                if (v > m) m = v;
            end
            r[l*8 +: 8] = 8'(m);
        end
        return r;
    endfunction

    task automatic clear_q();
        q_dout.delete(); q_idx.delete(); q_done.delete();
        q_cyc.delete(); exp_cyc.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(int w, int h, int kind, bit gaps);
        q_width  = W_SIZE'(w);
        q_height = W_SIZE'(h);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < w * h; p++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    vld_i = 1'b0;
                    tick();
                end
            end
            vld_i = 1'b1;
            din   = pix(kind, p);
            if (((p / w) % 2 == 1) && ((p % w) % 2 == 1))
                exp_cyc.push_back(cyc + 1);
            tick();
        end
        vld_i = 1'b0;
    endtask

    task automatic wait_out(int n);
        for (int i = 0; i < 50 && q_dout.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; vld_i = 1'b0; din = '0;
        q_width = 4; q_height = 4;
        repeat (3) tick();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", busy); end
        nvec++; if (vld_o !== 1'b0) begin nerr++; $display("FAIL rst_vld got %b want 0", vld_o); end
        nvec++; if (dout !== '0) begin nerr++; $display("FAIL rst_dout got %h want 0", dout); end
        nvec++; if (out_count !== '0) begin nerr++; $display("FAIL rst_cnt got %0d want 0", out_count); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done got %b want 0", done); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int eb[4];
        logic [7:0] e8;
        eb = '{5, 7, 13, 15};
        clear_q();
        run_frame(4, 4, 0, 1'b0);
        wait_out(4);
        nvec++; if (q_dout.size() != 4) begin nerr++; $display("FAIL basic_n got %0d want 4", q_dout.size()); end
        for (int i = 0; i < q_dout.size() && i < 4; i++) begin
            e8 = 8'(eb[i]);
            nvec++; if (q_dout[i] !== {To{e8}}) begin nerr++; $display("FAIL basic_dout[%0d] got %h want %h", i, q_dout[i], {To{e8}}); end
            nvec++; if (q_idx[i] !== i) begin nerr++; $display("FAIL basic_idx[%0d] got %0d want %0d", i, q_idx[i], i); end
            nvec++; if (q_done[i] !== (i == 3)) begin nerr++; $display("FAIL basic_done[%0d] got %b want %b", i, q_done[i], i == 3); end
            nvec++; if (q_cyc[i] !== exp_cyc[i]) begin nerr++; $display("FAIL basic_lat[%0d] got %0d want %0d", i, q_cyc[i], exp_cyc[i]); end
        end
        tick();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL basic_idle got %b want 0", busy); end
    endtask

    task automatic test_signed();
        clear_q();
        run_frame(4, 4, 1, 1'b0);
        wait_out(4);
        nvec++; if (q_dout.size() != 4) begin nerr++; $display("FAIL sgn_n got %0d want 4", q_dout.size()); end
        for (int i = 0; i < q_dout.size() && i < 4; i++) begin
            nvec++; if (q_dout[i] !== model(1, 4, i)) begin nerr++; $display("FAIL sgn_dout[%0d] got %h want %h", i, q_dout[i], model(1, 4, i)); end
        end
        tick();
    endtask

    task automatic test_gaps();
        clear_q();
        run_frame(4, 4, 0, 1'b1);
        wait_out(4);
        nvec++; if (q_dout.size() != 4) begin nerr++; $display("FAIL gap_n got %0d want 4", q_dout.size()); end
        for (int i = 0; i < q_dout.size() && i < 4; i++) begin
            nvec++; if (q_dout[i] !== model(0, 4, i)) begin nerr++; $display("FAIL gap_dout[%0d] got %h want %h", i, q_dout[i], model(0, 4, i)); end
            nvec++; if (q_idx[i] !== i) begin nerr++; $display("FAIL gap_idx[%0d] got %0d want %0d", i, q_idx[i], i); end
            nvec++; if (q_cyc[i] !== exp_cyc[i]) begin nerr++; $display("FAIL gap_lat[%0d] got %0d want %0d", i, q_cyc[i], exp_cyc[i]); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        int k;
        clear_q();
        run_frame(4, 4, 0, 1'b0);
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL b2b_done1 got %b want 1", done); end
        tick();
        run_frame(6, 2, 0, 1'b0);
        wait_out(7);
        nvec++; if (q_dout.size() != 7) begin nerr++; $display("FAIL b2b_n got %0d want 7", q_dout.size()); end
        for (int i = 0; i < q_dout.size() && i < 7; i++) begin
            k = (i < 4) ? i : i - 4;
            e = (i < 4) ? model(0, 4, k) : model(0, 6, k);
            nvec++; if (q_dout[i] !== e) begin nerr++; $display("FAIL b2b_dout[%0d] got %h want %h", i, q_dout[i], e); end
            nvec++; if (q_idx[i] !== k) begin nerr++; $display("FAIL b2b_idx[%0d] got %0d want %0d", i, q_idx[i], k); end
            nvec++; if (q_done[i] !== (i == 3 || i == 6)) begin nerr++; $display("FAIL b2b_done[%0d] got %b", i, q_done[i]); end
        end
        tick();
    endtask

    task automatic test_abort();
        clear_q();
        q_width = 4; q_height = 4;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < 9; p++) begin
            vld_i = 1'b1;
            din   = pix(0, p);
            start = (p == 4);
            tick();
        end
        start = 1'b0;
        din = pix(0, 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vld_i = 1'b0;
        nvec++; if (q_dout.size() != 2) begin nerr++; $display("FAIL abort_pre_n got %0d want 2", q_dout.size()); end
        if (q_dout.size() == 2) begin
            nvec++; if (q_dout[1] !== model(0, 4, 1)) begin nerr++; $display("FAIL abort_pre_dout got %h want %h", q_dout[1], model(0, 4, 1)); end
            nvec++; if (q_idx[1] !== 1) begin nerr++; $display("FAIL abort_pre_idx got %0d want 1", q_idx[1]); end
        end
        for (int p = 10; p < 16; p++) begin
            vld_i = 1'b1;
            din   = pix(0, p);
            tick();
        end
        vld_i = 1'b0;
        repeat (5) tick();
        nvec++; if (q_dout.size() != 2) begin nerr++; $display("FAIL abort_post_n got %0d want 2", q_dout.size()); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL abort_busy got %b want 0", busy); end
        clear_q();
        run_frame(4, 4, 0, 1'b0);
        wait_out(4);
        nvec++; if (q_dout.size() != 4) begin nerr++; $display("FAIL abort_new_n got %0d want 4", q_dout.size()); end
        for (int i = 0; i < q_dout.size() && i < 4; i++) begin
            nvec++; if (q_dout[i] !== model(0, 4, i)) begin nerr++; $display("FAIL abort_new_dout[%0d] got %h want %h", i, q_dout[i], model(0, 4, i)); end
            nvec++; if (q_idx[i] !== i) begin nerr++; $display("FAIL abort_new_idx[%0d] got %0d want %0d", i, q_idx[i], i); end
        end
        nvec++; if (stray_done !== 0) begin nerr++; $display("FAIL stray_done got %0d want 0", stray_done); end
        tick();
    endtask

    task automatic test_max_width();
        int n;
        n = MAX_W / 2;
        clear_q();
        run_frame(MAX_W, 2, 2, 1'b0);
        wait_out(n);
        nvec++; if (q_dout.size() != n) begin nerr++; $display("FAIL maxw_n got %0d want %0d", q_dout.size(), n); end
        for (int i = 0; i < q_dout.size() && i < n; i++) begin
            nvec++; if (q_dout[i] !== model(2, MAX_W, i)) begin nerr++; $display("FAIL maxw_dout[%0d] got %h want %h", i, q_dout[i], model(2, MAX_W, i)); end
            nvec++; if (q_idx[i] !== i) begin nerr++; $display("FAIL maxw_idx[%0d] got %0d want %0d", i, q_idx[i], i); end
        end
        if (q_done.size() == n) begin
            nvec++; if (q_done[n-1] !== 1'b1) begin nerr++; $display("FAIL maxw_done got %b want 1", q_done[n-1]); end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_gaps();
        test_back_to_back();
        test_abort();
        test_max_width();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
